// File: rtl/fourphase_tx_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : fourphase_tx_bridge
//  Description : Clocked-to-asynchronous boundary stage. Bytes from the
//                clocked side are buffered in a small FIFO and sent, one at a
//                time, on a four-phase return-to-zero bundled-data channel
//                (req_o / data_o). The acknowledge from the downstream
//                C-element stage (ack_i) is brought in through a two-flop
//                synchroniser.
//
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                in_valid/in_ready   - upstream handshake (in_ready = !full,
//                in_data               registered)
//                req_o, data_o       - four-phase request + bundled data
//                                      (both registered)
//                ack_i               - asynchronous acknowledge
//                busy                - FSM not idle or FIFO not empty
//                err_timeout         - sticky: a wait state lasted TIMEOUT
//                                      cycles
//                tx_count            - completed handshakes, wraps at 256
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fourphase_tx_bridge #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,      // power of two, >= 2
    parameter int TIMEOUT = 255     // 1 .. 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    output logic             busy,
    output logic             err_timeout,
    output logic [7:0]       tx_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_AW      = $clog2(DEPTH);
    localparam int          c_PW      = c_AW + 1;   // extra bit tells full from empty
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_SETUP   = 2'd1;
    localparam logic [1:0]  c_WAIT_HI = 2'd2;
    localparam logic [1:0]  c_WAIT_LO = 2'd3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic             r_ack_meta;
    logic             r_ack_s;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic             r_in_ready;

    logic [1:0]       r_state;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_tmo_cnt;
    logic             r_err;
    logic [7:0]       r_tx_count;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;
    logic [c_PW-1:0]  w_count_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_head;
    logic             w_tmo_hit;

    // ------------------------------------------------------------------------
    // Acknowledge synchroniser. An ack_i change lands in r_ack_s on the
    // second edge after it occurs; the FSM reacts on the edge after that.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= ack_i;
            r_ack_s    <= r_ack_meta;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = in_valid && r_in_ready;
    // Pop only from IDLE, and never while a stale acknowledge is still high:
    // raising req against ack_s=1 would break the return-to-zero protocol.
    assign w_pop   = (r_state == c_IDLE) && !w_empty && !r_ack_s;
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_full_nxt   = (w_count_nxt == c_PW'(DEPTH));

    // Storage is not reset; the pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= in_data;
        end
    end

    // in_ready is registered from the next-cycle fill level, so a full FIFO
    // keeps in_ready low even in a cycle that pops (no pass-through).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_in_ready <= !w_full_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    // Fires on the cycle the wait counter steps onto TIMEOUT; the counter
    // then holds there and the flag stays set until reset.
    assign w_tmo_hit = (r_tmo_cnt == (c_TIMEOUT - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_tx_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        // data_o only ever changes here, one full cycle
                        // before req_o rises.
                        r_data  <= w_head;
                        r_state <= c_SETUP;
                    end
                end

                c_SETUP: begin
                    r_req     <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= c_WAIT_HI;
                end

                c_WAIT_HI: begin
                    if (r_ack_s) begin
                        r_req     <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= c_WAIT_LO;
                    end else begin
                        if (r_tmo_cnt != c_TIMEOUT) begin
                            r_tmo_cnt <= r_tmo_cnt + 16'd1;
                        end
                        if (w_tmo_hit) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                c_WAIT_LO: begin
                    if (!r_ack_s) begin
                        r_tx_count <= r_tx_count + 8'd1;
                        r_state    <= c_IDLE;
                    end else begin
                        if (r_tmo_cnt != c_TIMEOUT) begin
                            r_tmo_cnt <= r_tmo_cnt + 16'd1;
                        end
                        if (w_tmo_hit) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign req_o       = r_req;
    assign data_o      = r_data;
    assign err_timeout = r_err;
    assign tx_count    = r_tx_count;
    assign busy        = (r_state != c_IDLE) || !w_empty;

endmodule
`default_nettype wire
